// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Brief  : Shared op encodings, FSM states and iteration count for muldiv_ctrl.
// Rev    : 1.0
// ============================================================================
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Magnitude of a signed operand; unsigned ops pass the raw value through.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module : muldiv_ctrl
// Brief  : Iterative 32x32 multiply / 32/32 divide unit with HI/LO results.
// Rev    : 1.0
// ============================================================================
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int ITER = muldiv_pkg::ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_op;
  logic [63:0] r_acc;
  logic [31:0] r_opr;
  logic [5:0]  r_cnt;
  logic        r_sign1;
  logic        r_sign2;

  logic        w_in_signed;
  logic        w_in_dbz;
  logic        w_last;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic [32:0] w_div_trial;
  logic [63:0] w_div_step;
  logic        w_neg_res;
  logic        w_neg_rem;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_in_signed = op_is_signed(op);
  assign w_in_dbz    = op_is_div(op) && (op2 == 32'd0);
  assign w_last      = (r_cnt == 6'(ITER - 1));

  // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opr} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

  // Restoring divide: shifted partial remainder may need 33 bits before subtracting.
  assign w_div_trial = r_acc[63:31] - {1'b0, r_opr};
  assign w_div_step  = w_div_trial[32] ? {r_acc[62:0], 1'b0}
                                       : {w_div_trial[31:0], r_acc[30:0], 1'b1};

  assign w_neg_res = op_is_signed(r_op) && (r_sign1 ^ r_sign2);
  assign w_neg_rem = op_is_signed(r_op) && r_sign1;
  assign w_prod    = w_neg_res ? (~r_acc + 64'd1) : r_acc;
  assign w_quot    = w_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem     = w_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_state_nxt = w_in_dbz ? S_DONE : S_RUN;
        S_RUN:  if (w_last) w_state_nxt = S_FIX;
        S_FIX:  w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= 2'd0;
      r_acc       <= 64'd0;
      r_opr       <= 32'd0;
      r_cnt       <= 6'd0;
      r_sign1     <= 1'b0;
      r_sign2     <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op        <= op;
          r_cnt       <= 6'd0;
          r_sign1     <= op1[31];
          r_sign2     <= op2[31];
          div_by_zero <= w_in_dbz;
          if (w_in_dbz) begin
            hi <= op1;
            lo <= 32'hFFFF_FFFF;
          end else if (op_is_div(op)) begin
            r_acc <= {32'd0, mag32(op1, w_in_signed)};
            r_opr <= mag32(op2, w_in_signed);
          end else begin
            r_acc <= {32'd0, mag32(op2, w_in_signed)};
            r_opr <= mag32(op1, w_in_signed);
          end
        end
        S_RUN: begin
          r_acc <= op_is_div(r_op) ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (op_is_div(r_op)) {hi, lo} <= {w_rem, w_quot};
          else                 {hi, lo} <= w_prod;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_ctrl
// Brief  : Directed vector table plus corner-case sequences for muldiv_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_ctrl #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edges after the start-sampling edge until done is seen (0 = same edge).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[1]  = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[3]  = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
    vecs[4]  = '{2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 0};
    vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
    vecs[6]  = '{2'd1, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 33};
    vecs[7]  = '{2'd0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 33};
    vecs[8]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33};
    vecs[9]  = '{2'd3, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 1'b0, 33};
    vecs[10] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 33};
    vecs[11] = '{2'd2, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      chk($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].exp_dbz));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {62'd0, done, busy}, 64'd0);
    end

    // Start held high through RUN and DONE must be ignored; hi/lo hold during RUN.
    launch(2'd3, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 2'd1; op1 = 32'd5; op2 = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_hilo_in_run", {hi, lo}, {32'hFFFF_FFF8, 32'hFFFF_FFFF});
    chk("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
    wait_done(lat);
    chk("busy_ignore_hilo", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk); #1;
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_done", 64'(busy), 64'd0);

    // flush together with start: flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1; op1 = 32'd3; op2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", 64'(busy), 64'd0);

    // MULTU 3x4 flushed in RUN cycle 10.
    launch(2'd1, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hilo_kept", {hi, lo}, {32'd2, 32'd14});

    // Reset pulsed mid-DIV, then a fresh op.
    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_clear", {60'd0, busy, done, div_by_zero, 1'b0}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; op = 2'd3; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_then_start_accepted", 64'(busy), 64'd1);
    wait_done(lat);
    chk("rst_then_latency", 64'(lat), 64'd33);
    chk("rst_then_hilo", {hi, lo}, {32'd2, 32'd14});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
